operand_entry: RTL

OPERAND_ENTRY -- requirements
Module: operand_entry

---
 rtl/alu_pkg.sv | 14 +
 rtl/button_debounce.sv | 62 ++++++
 rtl/operand_entry.sv | 84 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Types and constants shared by the operand entry, ALU and display blocks.
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int OP_W       = 4;

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        ENTER_OP = 2'd2,
        PRESENT  = 2'd3
    } entry_state_t;

endpackage

// File: rtl/button_debounce.sv
// Raw push button to single-cycle press pulse: 2-flop synchronizer, stability counter, rising-edge detect.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic             armed;
    logic [1:0]       fill;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // The level flips only after the input has disagreed with it for DEBOUNCE_CYCLES straight cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A button still held through reset must be seen released before it may generate a press;
    // fill waits out the synchronizer so its reset zeros are not mistaken for a release.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill    <= 2'b00;
            armed   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            fill    <= {fill[0], 1'b1};
            armed   <= armed | (fill[1] & ~sync2);
            level_d <= level;
            press   <= level & ~level_d & armed;
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Button-driven entry of operand A, operand B and opcode, presented to the ALU with a valid/ack handshake.
module operand_entry
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DATA_W          = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_next,
    input  logic              btn_clr,
    input  logic              op_ack,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [OP_W-1:0]   op,
    output logic              op_valid,
    output logic [1:0]        stage
);

    entry_state_t state;
    entry_state_t state_next;
    logic         next_press;
    logic         clr_press;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .press (next_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clr),
        .press (clr_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ENTER_A;
        end else begin
            state <= state_next;
        end
    end

    // Clear overrides both the next button and the ALU acknowledge.
    always_comb begin
        state_next = state;
        if (clr_press) begin
            state_next = ENTER_A;
        end else begin
            case (state)
                ENTER_A:  if (next_press) state_next = ENTER_B;
                ENTER_B:  if (next_press) state_next = ENTER_OP;
                ENTER_OP: if (next_press) state_next = PRESENT;
                PRESENT:  if (op_ack)     state_next = ENTER_A;
                default:  state_next = ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_press) begin
            a  <= '0;
            b  <= '0;
            op <= '0;
        end else if (next_press) begin
            case (state)
                ENTER_A:  a  <= sw;
                ENTER_B:  b  <= sw;
                ENTER_OP: op <= sw[OP_W-1:0];
                default:  ;
            endcase
        end
    end

    always_comb begin
        op_valid = (state == PRESENT);
        stage    = state;
    end

endmodule
